// File: rtl/qminmax_pkg.sv
// Shared types and constants for the streaming min/max reducer family.
package qminmax_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } qminmax_state_t;

    localparam int MODE_MAX  = 0;
    localparam int MODE_MIN  = 1;
    localparam int TIE_FIRST = 0;
    localparam int TIE_LAST  = 1;

endpackage

// File: rtl/qminmax_reduce_if.sv
// Valid/ready data-transfer interface (DTI); producer drives data and dvalid, consumer drives dready.
interface dti #(
    parameter int W = 8
);
    logic         dvalid;
    logic         dready;
    logic [W-1:0] data;

    modport producer (output dvalid, output data, input  dready);
    modport consumer (input  dvalid, input  data, output dready);
    modport master   (output dvalid, output data, input  dready);
    modport slave    (input  dvalid, input  data, output dready);

endinterface

// File: rtl/qminmax_reduce_minmax_cmp.sv
// Combinational "is candidate a better than incumbent b" for min/max reductions.
module minmax_cmp
    import qminmax_pkg::*;
#(
    parameter int DIN    = 16,
    parameter int SIGNED = 0,
    parameter int MODE   = MODE_MAX,
    parameter int TIE    = TIE_FIRST
) (
    input  logic [DIN-1:0] a,
    input  logic [DIN-1:0] b,
    output logic           better
);

    logic gt;
    logic eq;
    logic lt;

    always_comb begin
        gt     = 1'b0;
        eq     = (a == b);
        better = 1'b0;
        if (SIGNED != 0) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
        lt = !gt && !eq;
        // Ties only move the winner when the last occurrence is preferred.
        if (MODE == MODE_MIN) begin
            better = lt || ((TIE == TIE_LAST) && eq);
        end else begin
            better = gt || ((TIE == TIE_LAST) && eq);
        end
    end

endmodule

// File: rtl/qminmax_reduce.sv
// Streaming min/max reduction: one {ovf, idx, value} result per eot-terminated transaction.
module qminmax_reduce
    import qminmax_pkg::*;
#(
    parameter int DIN    = 16,
    parameter int SIGNED = 0,
    parameter int MODE   = MODE_MAX,
    parameter int TIE    = TIE_FIRST,
    parameter int CNT_W  = 8
) (
    input  logic   clk,
    input  logic   rst,
    dti.consumer   din,
    dti.producer   dout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    qminmax_state_t   state;
    qminmax_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DIN-1:0]   best;
    logic [CNT_W-1:0] best_idx;
    logic             ovf;

    logic [DIN-1:0]   value;
    logic             eot;
    logic             take;
    logic             give;
    logic             better;

    assign value = din.data[DIN-1:0];
    assign eot   = din.data[DIN];

    minmax_cmp #(
        .DIN    (DIN),
        .SIGNED (SIGNED),
        .MODE   (MODE),
        .TIE    (TIE)
    ) u_cmp (
        .a      (value),
        .b      (best),
        .better (better)
    );

    always_comb begin
        state_nxt   = state;
        din.dready  = 1'b0;
        dout.dvalid = 1'b0;
        take        = 1'b0;
        give        = 1'b0;
        case (state)
            ACC: begin
                din.dready = 1'b1;
                take       = din.dvalid;
                if (take && eot) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                dout.dvalid = 1'b1;
                give        = dout.dready;
                if (give) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    assign dout.data = {ovf, best_idx, best};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            best     <= '0;
            best_idx <= '0;
            ovf      <= 1'b0;
        end else if (take) begin
            if (cnt == '0) begin
                best     <= value;
                best_idx <= '0;
            end else if (better) begin
                best     <= value;
                best_idx <= cnt;
            end
            // Counter sticks at its maximum; any element accepted there marks the index as ambiguous.
            if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (give) begin
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

endmodule
